// File: rtl/csa_mult_pipe.sv
// csa_mult_pipe: pipelined WIDTH x WIDTH multiplier. Partial products are
//   AND terms (unsigned) or Baugh-Wooley terms (signed). A 3:2 carry-save
//   tree reduces them, and a final carry-propagate add gives the exact
//   2*WIDTH product.
// Latency: STAGES register stages. A transaction accepted at edge t appears
//   on product after edge t+STAGES-1. Throughput is one result per cycle.
// Backpressure: the whole pipe holds whenever out_valid && !out_ready.
//   in_ready equals the advance condition.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   in_valid/in_ready, a, b, is_signed, in_tag   operand handshake
//   out_valid/out_ready, product, out_tag        result handshake
//   busy             some stage holds a valid transaction
module csa_mult_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int RW     = 2 * WIDTH;
  // WIDTH partial-product rows plus one row for the signed correction constant.
  localparam int NR     = WIDTH + 1;
  localparam int MAXLEV = 16;

  typedef logic [NR-1:0][RW-1:0] rows_t;

  // Row count left after applying n carry-save levels to r0 rows.
  function automatic int rows_after(input int r0, input int n);
    int r;
    r = r0;
    for (int i = 0; i < MAXLEV; i++) begin
      if (i < n && r > 2) r = r - r / 3;
    end
    return r;
  endfunction

  // Number of 3:2 levels needed to bring r0 rows down to two.
  function automatic int count_levels(input int r0);
    int r;
    int n;
    r = r0;
    n = 0;
    for (int i = 0; i < MAXLEV; i++) begin
      if (r > 2) begin
        r = r - r / 3;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int NLEV = count_levels(NR);
  localparam int NSEG = (STAGES > 1) ? STAGES - 1 : 1;

  // Levels placed in inner segment k (1-based). Earlier segments take the
  // remainder, so the split is as even as possible.
  function automatic int seg_levels(input int k);
    return NLEV / NSEG + (((k - 1) < (NLEV % NSEG)) ? 1 : 0);
  endfunction

  function automatic int levels_before(input int k);
    int s;
    s = 0;
    for (int j = 1; j <= 8; j++) begin
      if (j < k) s = s + seg_levels(j);
    end
    return s;
  endfunction

  // Partial products. In signed mode the cross terms that involve exactly
  // one sign bit are inverted. The constant 2^W + 2^(2W-1) is then added,
  // which makes the modular sum equal the two's-complement product.
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] av,
                                   input logic [WIDTH-1:0] bv,
                                   input logic sg);
    rows_t p;
    logic  bit_v;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        bit_v = av[j] & bv[i];
        if (sg && ((i == WIDTH - 1) != (j == WIDTH - 1))) bit_v = ~bit_v;
        p[i][i+j] = bit_v;
      end
    end
    if (sg) p[WIDTH] = (RW'(1) << WIDTH) | (RW'(1) << (RW - 1));
    return p;
  endfunction

  // Apply n carry-save levels to the r0 live rows, which occupy the low
  // indices. Each full group of three rows becomes a sum and a shifted
  // carry. Leftover rows pass through unchanged. Unused rows stay zero.
  function automatic rows_t csa_apply(input rows_t x0, input int r0, input int n);
    rows_t         x;
    rows_t         y;
    int            r;
    int            g;
    logic [RW-1:0] s;
    logic [RW-1:0] c;
    x = x0;
    r = r0;
    for (int l = 0; l < MAXLEV; l++) begin
      if (l < n && r > 2) begin
        y = '0;
        g = r / 3;
        for (int k = 0; k < NR / 3; k++) begin
          if (k < g) begin
            s = x[3*k] ^ x[3*k+1] ^ x[3*k+2];
            c = (x[3*k] & x[3*k+1]) | (x[3*k] & x[3*k+2]) | (x[3*k+1] & x[3*k+2]);
            y[2*k]   = s;
            y[2*k+1] = {c[RW-2:0], 1'b0};
          end
        end
        for (int m = 0; m < 2; m++) begin
          if (m < r % 3) y[2*g+m] = x[3*g+m];
        end
        x = y;
        r = r - g;
      end
    end
    return x;
  endfunction

  // Final carry-propagate add. After the full tree only rows 0 and 1 can be
  // non-zero. The other terms are constant zero and drop out, so this is a
  // two-operand adder.
  function automatic logic [RW-1:0] sum_rows(input rows_t x);
    logic [RW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NR; i++) acc = acc + x[i];
    return acc;
  endfunction

  // ------------------------------------------------------------------
  // Pipeline control: one global advance. Bubbles travel as valid = 0.
  // ------------------------------------------------------------------
  logic              advance;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic [RW-1:0]     product_q, product_d;
  logic [RW-1:0]     final_sum;
  logic              busy_q, busy_d;

  assign advance  = !vld_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  always_comb begin
    vld_d     = vld_q;
    product_d = product_q;
    for (int k = 0; k < STAGES; k++) tag_d[k] = tag_q[k];
    if (advance) begin
      vld_d[0] = in_valid;
      tag_d[0] = in_tag;
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
      product_d = final_sum;
    end
    // busy follows the next-state valid bits, so it is registered on the
    // same edge as those bits.
    busy_d = |vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
    end else begin
      vld_q     <= vld_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      for (int k = 0; k < STAGES; k++) tag_q[k] <= tag_d[k];
    end
  end

  // ------------------------------------------------------------------
  // Datapath. Row registers sit at every stage boundary except the last.
  // The last register holds the finished product.
  // ------------------------------------------------------------------
  if (STAGES == 1) begin : g_comb
    assign final_sum = sum_rows(csa_apply(gen_pp(a, b, is_signed), NR, NLEV));
  end else begin : g_pipe
    for (genvar gk = 0; gk < STAGES - 1; gk++) begin : g_stg
      rows_t src;
      rows_t rows_d;
      rows_t rows_q;

      if (gk == 0) begin : g_pp
        assign src = gen_pp(a, b, is_signed);
      end else begin : g_csa
        assign src = csa_apply(g_stg[gk-1].rows_q,
                               rows_after(NR, levels_before(gk)),
                               seg_levels(gk));
      end

      always_comb begin
        rows_d = rows_q;
        if (advance) rows_d = src;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rows_q <= '0;
        else     rows_q <= rows_d;
      end
    end

    assign final_sum = sum_rows(csa_apply(g_stg[STAGES-2].rows_q,
                                          rows_after(NR, levels_before(STAGES - 1)),
                                          seg_levels(STAGES - 1)));
  end

  assign out_valid = vld_q[STAGES-1];
  assign product   = product_q;
  assign out_tag   = tag_q[STAGES-1];
  assign busy      = busy_q;

endmodule

// File: tb/tb_csa_mult_pipe.sv
// Bench for csa_mult_pipe: an 8-bit 3-stage build plus 16-bit builds with
// 1 and 8 stages. A queue-based reference model computes exact products
// with plain integer arithmetic.
module tb_csa_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 8-bit, 3-stage instance
  logic        iv8, rdy8, s8, ov8, ordy8, busy8;
  logic [7:0]  a8, b8;
  logic [3:0]  tag8, otag8;
  logic [15:0] p8;

  csa_mult_pipe #(.WIDTH(8), .STAGES(3), .TAG_W(4)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
    .is_signed(s8), .in_tag(tag8), .out_valid(ov8), .out_ready(ordy8),
    .product(p8), .out_tag(otag8), .busy(busy8));

  // 16-bit instances with shared stimulus
  logic        iv16, s16, ordy16;
  logic [15:0] a16, b16;
  logic [3:0]  tag16;
  logic        rdy_s1, ov_s1, busy_s1, rdy_s8, ov_s8, busy_s8;
  logic [31:0] p_s1, p_s8;
  logic [3:0]  otag_s1, otag_s8;

  csa_mult_pipe #(.WIDTH(16), .STAGES(1), .TAG_W(4)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy_s1), .a(a16), .b(b16),
    .is_signed(s16), .in_tag(tag16), .out_valid(ov_s1), .out_ready(ordy16),
    .product(p_s1), .out_tag(otag_s1), .busy(busy_s1));

  csa_mult_pipe #(.WIDTH(16), .STAGES(8), .TAG_W(4)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy_s8), .a(a16), .b(b16),
    .is_signed(s16), .in_tag(tag16), .out_valid(ov_s8), .out_ready(ordy16),
    .product(p_s8), .out_tag(otag_s8), .busy(busy_s8));

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q_s1[$];
  exp_t q_s8[$];

  logic        chk_lat = 1'b0;
  logic        prev_stall8 = 1'b0;
  logic [15:0] prev_p8;
  logic [3:0]  prev_t8;

  // Exact product of w-bit operands, reduced modulo 2^(2w).
  function automatic logic [31:0] mul_ref(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic sg);
    longint      x, y, pr;
    logic [63:0] msk;
    x = longint'(av);
    y = longint'(bv);
    if (sg && av[w-1]) x = x - (longint'(1) << w);
    if (sg && bv[w-1]) y = y - (longint'(1) << w);
    pr  = x * y;
    msk = (64'd1 << (2 * w)) - 64'd1;
    return 32'(pr & msk);
  endfunction

  task automatic step8(input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic sg, input logic [3:0] tv, input logic ordy,
                       output logic took);
    exp_t e;
    iv8 = v; a8 = av; b8 = bv; s8 = sg; tag8 = tv; ordy8 = ordy;
    #1;
    if (prev_stall8) begin
      checks++;
      if (ov8 !== 1'b1 || p8 !== prev_p8 || otag8 !== prev_t8) begin
        errors++;
        $display("FAIL hold8 valid=%b product=%h tag=%h required valid=1 product=%h tag=%h",
                 ov8, p8, otag8, prev_p8, prev_t8);
      end
    end
    checks++;
    if (rdy8 !== (!ov8 || ordy)) begin
      errors++;
      $display("FAIL in_ready8 got %b required %b", rdy8, (!ov8 || ordy));
    end
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious8 out_valid=1 product=%h required no output", p8);
      end else if (ordy) begin
        e = q8.pop_front();
        checks++;
        if (p8 !== e.prod[15:0] || otag8 !== e.tag) begin
          errors++;
          $display("FAIL result8 product=%h tag=%h required product=%h tag=%h",
                   p8, otag8, e.prod[15:0], e.tag);
        end
        if (chk_lat) begin
          checks++;
          if (cyc !== e.acc + 2) begin
            errors++;
            $display("FAIL latency8 seen at edge %0d required edge %0d", cyc, e.acc + 2);
          end
        end
      end
    end
    prev_stall8 = (ov8 === 1'b1) && !ordy;
    prev_p8 = p8;
    prev_t8 = otag8;
    took = v && (rdy8 === 1'b1);
    if (took) begin
      e.prod = mul_ref(8, {8'h00, av}, {8'h00, bv}, sg);
      e.tag  = tv;
      e.acc  = cyc + 1;
      q8.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain8();
    logic t;
    for (int i = 0; i < 40 && (q8.size() > 0 || ov8 === 1'b1); i++)
      step8(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, t);
    checks++;
    if (q8.size() != 0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL drain8 remaining=%0d busy=%b required 0 and 0", q8.size(), busy8);
    end
  endtask

  task automatic step16(input logic v, input logic [15:0] av, input logic [15:0] bv,
                        input logic sg, input logic [3:0] tv);
    exp_t e;
    iv16 = v; a16 = av; b16 = bv; s16 = sg; tag16 = tv; ordy16 = 1'b1;
    #1;
    checks++;
    if (rdy_s1 !== 1'b1 || rdy_s8 !== 1'b1) begin
      errors++;
      $display("FAIL in_ready16 got %b/%b required 1/1", rdy_s1, rdy_s8);
    end
    if (ov_s1 === 1'b1) begin
      checks++;
      if (q_s1.size() == 0) begin
        errors++;
        $display("FAIL spurious_s1 product=%h required no output", p_s1);
      end else begin
        e = q_s1.pop_front();
        if (p_s1 !== e.prod || otag_s1 !== e.tag || cyc !== e.acc) begin
          errors++;
          $display("FAIL result_s1 product=%h tag=%h edge=%0d required product=%h tag=%h edge=%0d",
                   p_s1, otag_s1, cyc, e.prod, e.tag, e.acc);
        end
      end
    end
    if (ov_s8 === 1'b1) begin
      checks++;
      if (q_s8.size() == 0) begin
        errors++;
        $display("FAIL spurious_s8 product=%h required no output", p_s8);
      end else begin
        e = q_s8.pop_front();
        if (p_s8 !== e.prod || otag_s8 !== e.tag || cyc !== e.acc + 7) begin
          errors++;
          $display("FAIL result_s8 product=%h tag=%h edge=%0d required product=%h tag=%h edge=%0d",
                   p_s8, otag_s8, cyc, e.prod, e.tag, e.acc + 7);
        end
      end
    end
    if (v) begin
      e.prod = mul_ref(16, av, bv, sg);
      e.tag  = tv;
      e.acc  = cyc + 1;
      q_s1.push_back(e);
      q_s8.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain16();
    for (int i = 0; i < 40 && (q_s1.size() > 0 || q_s8.size() > 0); i++)
      step16(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
    checks++;
    if (q_s1.size() != 0 || q_s8.size() != 0) begin
      errors++;
      $display("FAIL drain16 remaining=%0d/%0d required 0/0", q_s1.size(), q_s8.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; s8 = 0; tag8 = 0; ordy8 = 1;
    iv16 = 0; a16 = 0; b16 = 0; s16 = 0; tag16 = 0; ordy16 = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL reset_valid8 valid=%b busy=%b required 0 0", ov8, busy8);
    end
    checks++;
    if (p8 !== 16'h0 || otag8 !== 4'h0) begin
      errors++; $display("FAIL reset_data8 product=%h tag=%h required 0 0", p8, otag8);
    end
    checks++;
    if (rdy8 !== 1'b1 || rdy_s1 !== 1'b1 || rdy_s8 !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b%b%b required 111", rdy8, rdy_s1, rdy_s8);
    end
    checks++;
    if (ov_s1 !== 1'b0 || ov_s8 !== 1'b0 || busy_s1 !== 1'b0 || busy_s8 !== 1'b0 ||
        p_s1 !== 32'h0 || p_s8 !== 32'h0) begin
      errors++; $display("FAIL reset16 valid=%b%b busy=%b%b product=%h/%h required all 0",
                         ov_s1, ov_s8, busy_s1, busy_s8, p_s1, p_s8);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic t;
    chk_lat = 1'b1;
    step8(1'b1, 8'hFF, 8'hFF, 1'b0, 4'd5, 1'b1, t);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++; $display("FAIL busy8 got %b required 1", busy8);
    end
    drain8();
  endtask

  task automatic test_back_to_back_signed();
    logic t;
    chk_lat = 1'b1;
    step8(1'b1, 8'h80, 8'h80, 1'b1, 4'd1, 1'b1, t);
    step8(1'b1, 8'h80, 8'h7F, 1'b1, 4'd2, 1'b1, t);
    step8(1'b1, 8'hFF, 8'h01, 1'b1, 4'd3, 1'b1, t);
    drain8();
  endtask

  task automatic test_stall();
    logic       t;
    logic       saw_block;
    logic [7:0] ra, rb;
    logic       rs;
    int         sent;
    chk_lat   = 1'b0;
    saw_block = 1'b0;
    sent      = 0;
    ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
    for (int i = 0; i < 40 && sent < 10; i++) begin
      step8(1'b1, ra, rb, rs, 4'(sent), !(i >= 4 && i <= 9), t);
      if (t) begin
        sent++;
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      end else begin
        saw_block = 1'b1;
      end
    end
    checks++;
    if (sent != 10 || saw_block !== 1'b1) begin
      errors++; $display("FAIL stall_accept sent=%0d blocked=%b required 10 1", sent, saw_block);
    end
    drain8();
  endtask

  task automatic test_reset_mid();
    logic t;
    chk_lat = 1'b0;
    step8(1'b1, 8'h11, 8'h22, 1'b0, 4'd1, 1'b1, t);
    step8(1'b1, 8'h33, 8'h44, 1'b1, 4'd2, 1'b1, t);
    step8(1'b1, 8'h55, 8'h66, 1'b0, 4'd3, 1'b1, t);
    iv8 = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
      errors++; $display("FAIL reset_mid valid=%b busy=%b product=%h required 0 0 0", ov8, busy8, p8);
    end
    @(negedge clk);
    rst = 1'b0;
    q8.delete();
    prev_stall8 = 1'b0;
    for (int i = 0; i < 6; i++) step8(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, t);
    chk_lat = 1'b1;
    step8(1'b1, 8'd3, 8'd4, 1'b0, 4'd9, 1'b1, t);
    drain8();
  endtask

  task automatic test_alt_mode();
    logic t;
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) step8(1'b1, 8'hF0, 8'h02, i[0], 4'(i), 1'b1, t);
    drain8();
  endtask

  task automatic test_wide();
    step16(1'b1, 16'h8000, 16'h8000, 1'b1, 4'd1);
    step16(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 4'd2);
    step16(1'b1, 16'h8000, 16'h7FFF, 1'b1, 4'd3);
    for (int i = 0; i < 20; i++)
      step16(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 4'(i));
    drain16();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_signed();
    test_stall();
    test_reset_mid();
    test_alt_mode();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_mult_pipe.md
Name: csa_mult_pipe

Overview:
- Pipelined WIDTH x WIDTH multiplier for the 03_mult datapath.
- Generates WIDTH partial products and reduces them with a carry-save (3:2) tree, with the tree levels distributed across pipeline registers.
- A final carry-propagate adder produces the exact 2*WIDTH product.
- Adds over the plain CSA tree: per-transaction signed/unsigned mode, a user tag, a configurable pipeline depth, and a valid/ready handshake with backpressure.

Parameters:
- WIDTH, 16: operand width in bits, legal range 4..64.
- STAGES, 3: register stages from input acceptance to output, legal range 1..8.
- TAG_W, 4: width of the sideband tag carried with each transaction, legal range 1..16.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- in_valid, input, 1: operand set is valid.
- in_ready, output, 1: block can accept an operand set this cycle.
- a, input, WIDTH: multiplicand.
- b, input, WIDTH: multiplier.
- is_signed, input, 1: 1 = both operands are two's complement; 0 = both are unsigned.
- in_tag, input, TAG_W: sideband tag, returned unchanged with the result.
- out_valid, output, 1: product is valid.
- out_ready, input, 1: downstream accepts the product.
- product, output, 2*WIDTH: exact product.
- out_tag, output, TAG_W: tag of the transaction on product.
- busy, output, 1: at least one pipeline stage holds a valid transaction.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset:
  - Asserting rst immediately clears every stage valid bit, product, out_tag and busy to 0.
  - in_ready reads 1 while in reset and after reset.
  - Reset mid-operation discards all in-flight transactions; nothing is emitted after release.
- Handshake:
  - A transfer happens on a rising edge where valid && ready.
  - advance = !out_valid || out_ready, and in_ready = advance (combinational from out_valid and out_ready only).
  - When advance = 0 every stage holds. product, out_tag and out_valid stay stable until accepted.
  - in_valid is ignored while in_ready = 0.
- Pipeline:
  - STAGES register stages, each carrying {valid, data, is_signed, tag}.
  - Stage 1 captures the accepted operands. Bubbles propagate as valid = 0 entries.
  - When advance = 1, every stage shifts one position per edge.
- Latency and throughput:
  - A transaction accepted at edge t is presented on product/out_valid after edge t+STAGES-1.
  - STAGES = 1: the whole datapath is combinational from the inputs into a single output register, so the result is visible after edge t.
  - Throughput is 1 result per cycle when out_ready is held at 1.
- Arithmetic:
  - Partial products are generated Baugh-Wooley style when is_signed = 1 (inverted MSB terms plus constant correction) and as plain AND terms when is_signed = 0.
  - The CSA reduction proceeds until 2 rows remain (ps, pc), followed by a 2*WIDTH carry-propagate add.
  - The result is exact modulo 2^(2*WIDTH). No overflow is possible.
  - Mode is per transaction and may change every cycle.
- Level placement:
  - CSA levels are split across the STAGES-1 inner boundaries as evenly as possible, earlier stages taking the extra level.
  - The final adder is always in the last stage.
  - Placement affects timing only; cycle behaviour is fixed by the latency rule above.
- busy = OR of all stage valid bits, registered consistently with those bits.
- Boundary conditions:
  - out_ready = 0 with a full pipeline: in_ready = 0 and no data is lost or duplicated.
  - out_ready rising at the same edge as a new in_valid: the output retires and the new input is accepted on that same edge.
  - Back-to-back transactions with alternating is_signed each receive their own correct mode.

Test Plan:
- WIDTH=8, STAGES=3, is_signed=0, a=0xFF, b=0xFF, tag=5, out_ready=1 -> product=0xFE01 and out_tag=5, appearing after the 3rd edge counting the accept edge.
- WIDTH=8, is_signed=1: a=0x80, b=0x80 -> 0x4000; a=0x80, b=0x7F -> 0xC080; a=0xFF, b=0x01 -> 0xFFFF; issued back to back -> 3 consecutive out_valid cycles, in order.
- Stream of 10 random transactions with out_ready held 0 from cycle 4 to cycle 9 -> in_ready drops once the pipeline is full, product stays stable while stalled, and all 10 results are in order and match the reference model, with no loss or duplication.
- Assert rst for 1 cycle while 3 transactions are in flight -> out_valid and busy drop to 0 immediately, no stale result appears afterwards, and the next accepted a=3, b=4 gives 12.
- STAGES=1 and STAGES=8 builds, WIDTH=16, random signed and unsigned pairs including 0x8000 x 0x8000 signed (-> 0x40000000) and 0xFFFF x 0xFFFF unsigned (-> 0xFFFE0001) -> correct product at latencies 1 and 8 respectively.
- Alternate is_signed every cycle with a=0xF0, b=0x02 (WIDTH=8) -> results alternate 0x01E0 (unsigned) and 0xFFE0 (signed).
